// File: rtl/bp_cce_lite_pkg.sv
// Shared types for the lite CCE: LCE message structs, FSM states, processor geometry and block-offset width.
// Optional build macro BP_CCE_LITE_PERF_EN is consumed by the top, not here.
package bp_cce_lite_pkg;

  localparam int PADDR_W   = 40;
  localparam int LCE_ID_W  = 1;
  localparam int CCE_ID_W  = 1;
  localparam int LCE_ASSOC = 8;
  localparam int WAY_W     = $clog2(LCE_ASSOC);
  localparam int LCE_SETS  = 64;
  localparam int SET_W     = $clog2(LCE_SETS);
  localparam int DWORD_W   = 64;
  localparam int BLOCK_W   = 512;
  localparam int BLK_OFF_W = $clog2(BLOCK_W / 8);

  typedef enum logic [1:0] {
    e_lce_req_type_rd, e_lce_req_type_wr, e_lce_req_type_uc_rd, e_lce_req_type_uc_wr
  } lce_req_type_e;

  typedef enum logic [1:0] {
    e_lce_cmd_writeback, e_lce_cmd_data, e_lce_cmd_uc_data, e_lce_cmd_uc_st_done
  } lce_cmd_type_e;

  typedef enum logic [1:0] {
    e_lce_cce_coh_ack, e_lce_cce_resp_wb, e_lce_cce_resp_null_wb
  } lce_resp_type_e;

  typedef enum logic [1:0] {e_coh_I, e_coh_S, e_coh_E, e_coh_M} coh_state_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WB_CMD, ST_WB_RESP, ST_WB_MEM, ST_RD_MEM, ST_RD_RESP,
    ST_FILL_CMD, ST_ACK_WAIT, ST_UC_RD_MEM, ST_UC_RD_RESP, ST_UC_ST_MEM, ST_UC_DONE_CMD
  } cce_state_e;

  typedef struct packed {
    lce_req_type_e        msg_type;
    logic [LCE_ID_W-1:0]  src_id;
    logic [PADDR_W-1:0]   addr;
    logic [WAY_W-1:0]     lru_way;
    logic                 lru_dirty;
    logic [1:0]           size;
    logic [DWORD_W-1:0]   data;
  } bp_lce_req_s;

  typedef struct packed {
    logic [LCE_ID_W-1:0]  dst_id;
    logic [CCE_ID_W-1:0]  src_id;
    lce_cmd_type_e        msg_type;
    coh_state_e           state;
    logic [PADDR_W-1:0]   addr;
    logic [SET_W-1:0]     set_id;
    logic [WAY_W-1:0]     way_id;
    logic [BLOCK_W-1:0]   data;
  } bp_lce_cmd_s;

  typedef struct packed {
    logic [LCE_ID_W-1:0]  src_id;
    lce_resp_type_e       msg_type;
    logic [PADDR_W-1:0]   addr;
    logic [BLOCK_W-1:0]   data;
  } bp_lce_resp_s;

  localparam int LCE_REQ_W  = $bits(bp_lce_req_s);
  localparam int LCE_CMD_W  = $bits(bp_lce_cmd_s);
  localparam int LCE_RESP_W = $bits(bp_lce_resp_s);

  function automatic logic [PADDR_W-1:0] block_align(input logic [PADDR_W-1:0] a);
    return {a[PADDR_W-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_cce_lite_mem_if.sv
// Memory side of the lite CCE: drives the mem command, captures read data on yumi, runs the response watchdog.
// Command path is combinational pass-through; the sticky timeout flags a response later than mem_lat_max_p cycles.
module bp_cce_lite_mem_if
  import bp_cce_lite_pkg::*;
#(
  parameter int mem_lat_max_p = 1024
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               i_cmd_v,
  input  logic               i_we,
  input  logic               i_uc,
  input  logic [PADDR_W-1:0] i_addr,
  input  logic [BLOCK_W-1:0] i_data,
  input  logic               i_wait,
  output logic               o_resp_done,
  output logic               o_dat_vld,
  output logic [BLOCK_W-1:0] o_data,
  output logic               o_timeout,
  output logic [PADDR_W-1:0] mem_cmd_addr_o,
  output logic               mem_cmd_we_o,
  output logic               mem_cmd_uc_o,
  output logic [BLOCK_W-1:0] mem_cmd_data_o,
  output logic               mem_cmd_v_o,
  input  logic [BLOCK_W-1:0] mem_resp_data_i,
  input  logic               mem_resp_v_i,
  output logic               mem_resp_yumi_o
);

  localparam int CNT_W = $clog2(mem_lat_max_p + 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(mem_lat_max_p);

  logic [CNT_W-1:0]   r_wd_cnt;
  logic               r_dat_vld;
  logic               r_timeout;
  logic [BLOCK_W-1:0] r_data;
  logic               w_waiting;
  logic               w_resp_yumi;

  assign mem_cmd_v_o    = i_cmd_v;
  assign mem_cmd_we_o   = i_we;
  assign mem_cmd_uc_o   = i_uc;
  assign mem_cmd_addr_o = i_addr;
  assign mem_cmd_data_o = i_data;

  // Once data is captured the wait state may linger to issue its command; stop accepting and counting then.
  assign w_waiting       = i_wait & ~r_dat_vld;
  assign w_resp_yumi     = w_waiting & mem_resp_v_i;
  assign mem_resp_yumi_o = w_resp_yumi;
  assign o_resp_done     = w_resp_yumi;
  assign o_dat_vld       = r_dat_vld;
  assign o_data          = r_data;
  assign o_timeout       = r_timeout;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wd_cnt  <= '0;
      r_dat_vld <= 1'b0;
      r_timeout <= 1'b0;
      r_data    <= '0;
    end else begin
      if (w_resp_yumi) r_data <= mem_resp_data_i;
      r_dat_vld <= i_wait & (r_dat_vld | w_resp_yumi);
      if (!w_waiting) r_wd_cnt <= '0;
      else if (r_wd_cnt != LP_CNT_MAX) r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_waiting && (r_wd_cnt == LP_CNT_MAX)) r_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/bp_cce_lite_responder.sv
// Single-LCE, single-outstanding CCE: serves coherent misses (with optional writeback) and uncached accesses.
// Optional perf counters under BP_CCE_LITE_PERF_EN; new requests are held off (no yumi) while busy.
module bp_cce_lite_responder
  import bp_cce_lite_pkg::*;
#(
  parameter int cce_id_p      = 0,
  parameter int mem_lat_max_p = 1024
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [LCE_REQ_W-1:0]  lce_req_i,
  input  logic                  lce_req_v_i,
  output logic                  lce_req_yumi_o,
  output logic [LCE_CMD_W-1:0]  lce_cmd_o,
  output logic                  lce_cmd_v_o,
  input  logic                  lce_cmd_ready_i,
  input  logic [LCE_RESP_W-1:0] lce_resp_i,
  input  logic                  lce_resp_v_i,
  output logic                  lce_resp_yumi_o,
  output logic [PADDR_W-1:0]    mem_cmd_addr_o,
  output logic                  mem_cmd_we_o,
  output logic                  mem_cmd_uc_o,
  output logic [BLOCK_W-1:0]    mem_cmd_data_o,
  output logic                  mem_cmd_v_o,
  input  logic                  mem_cmd_ready_i,
  input  logic [BLOCK_W-1:0]    mem_resp_data_i,
  input  logic                  mem_resp_v_i,
  output logic                  mem_resp_yumi_o,
  output logic                  busy_o,
  output logic                  timeout_o
`ifdef BP_CCE_LITE_PERF_EN
  ,
  output logic [31:0]           perf_miss_o,
  output logic [31:0]           perf_wb_o,
  output logic [31:0]           perf_uc_o
`endif
);

  bp_lce_req_s        w_req;
  bp_lce_resp_s       w_resp;
  bp_lce_cmd_s        w_cmd;
  bp_lce_cmd_s        w_cmd_base;
  cce_state_e         r_state;
  cce_state_e         w_state_nxt;
  bp_lce_req_s        r_req;
  logic [PADDR_W-1:0] r_wb_addr;
  logic [BLOCK_W-1:0] r_wb_data;
  logic [PADDR_W-1:0] w_blk_addr;
  logic               w_req_yumi;
  logic               w_resp_yumi;
  logic               w_cmd_v;
  logic               w_wb_take;
  logic               w_mem_v;
  logic               w_mem_we;
  logic               w_mem_uc;
  logic [PADDR_W-1:0] w_mem_addr;
  logic [BLOCK_W-1:0] w_mem_data;
  logic               w_mem_wait;
  logic               w_mem_resp_done;
  logic               w_dat_vld;
  logic [BLOCK_W-1:0] w_blk_data;
  logic               w_unused;

  assign w_req      = bp_lce_req_s'(lce_req_i);
  assign w_resp     = bp_lce_resp_s'(lce_resp_i);
  assign w_blk_addr = block_align(r_req.addr);
  assign w_mem_wait = (r_state == ST_RD_RESP) || (r_state == ST_UC_RD_RESP);
  assign w_wb_take  = (r_state == ST_WB_RESP) && lce_resp_v_i &&
                      (w_resp.msg_type == e_lce_cce_resp_wb);
  assign w_unused   = ^{r_req.size, w_resp.src_id};

  always_comb begin
    w_cmd_base          = '0;
    w_cmd_base.dst_id   = r_req.src_id;
    w_cmd_base.src_id   = CCE_ID_W'(cce_id_p);
    w_cmd_base.addr     = w_blk_addr;
    w_cmd_base.set_id   = r_req.addr[BLK_OFF_W +: SET_W];
    w_cmd_base.way_id   = r_req.lru_way;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_yumi  = 1'b0;
    w_resp_yumi = 1'b0;
    w_cmd_v     = 1'b0;
    w_cmd       = '0;
    w_mem_v     = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_uc    = 1'b0;
    w_mem_addr  = '0;
    w_mem_data  = '0;
    case (r_state)
      ST_IDLE: begin
        // Reset gating keeps the combinational yumi at 0 while reset is held.
        w_req_yumi = lce_req_v_i & reset_n_i;
        if (w_req_yumi) begin
          case (w_req.msg_type)
            e_lce_req_type_rd,
            e_lce_req_type_wr:    w_state_nxt = w_req.lru_dirty ? ST_WB_CMD : ST_RD_MEM;
            e_lce_req_type_uc_rd: w_state_nxt = ST_UC_RD_MEM;
            default:              w_state_nxt = ST_UC_ST_MEM;
          endcase
        end
      end
      ST_WB_CMD: begin
        w_cmd_v      = 1'b1;
        w_cmd        = w_cmd_base;
        w_cmd.msg_type = e_lce_cmd_writeback;
        if (lce_cmd_ready_i) w_state_nxt = ST_WB_RESP;
      end
      ST_WB_RESP: begin
        if (lce_resp_v_i) begin
          w_resp_yumi = 1'b1;
          if (w_resp.msg_type == e_lce_cce_resp_wb)           w_state_nxt = ST_WB_MEM;
          else if (w_resp.msg_type == e_lce_cce_resp_null_wb) w_state_nxt = ST_RD_MEM;
        end
      end
      ST_WB_MEM: begin
        w_mem_v    = 1'b1;
        w_mem_we   = 1'b1;
        w_mem_addr = block_align(r_wb_addr);
        w_mem_data = r_wb_data;
        if (mem_cmd_ready_i) w_state_nxt = ST_RD_MEM;
      end
      ST_RD_MEM: begin
        w_mem_v    = 1'b1;
        w_mem_addr = w_blk_addr;
        if (mem_cmd_ready_i) w_state_nxt = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (w_mem_resp_done) w_state_nxt = ST_FILL_CMD;
      end
      ST_FILL_CMD: begin
        w_cmd_v        = 1'b1;
        w_cmd          = w_cmd_base;
        w_cmd.msg_type = e_lce_cmd_data;
        w_cmd.state    = (r_req.msg_type == e_lce_req_type_wr) ? e_coh_M : e_coh_E;
        w_cmd.data     = w_blk_data;
        if (lce_cmd_ready_i) w_state_nxt = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (lce_resp_v_i) begin
          w_resp_yumi = 1'b1;
          if (w_resp.msg_type == e_lce_cce_coh_ack) w_state_nxt = ST_IDLE;
        end
      end
      ST_UC_RD_MEM: begin
        w_mem_v    = 1'b1;
        w_mem_uc   = 1'b1;
        w_mem_addr = r_req.addr;
        if (mem_cmd_ready_i) w_state_nxt = ST_UC_RD_RESP;
      end
      ST_UC_RD_RESP: begin
        // Stays here after capture to return the dword; no ack follows an uncached load.
        if (w_dat_vld) begin
          w_cmd_v        = 1'b1;
          w_cmd          = w_cmd_base;
          w_cmd.msg_type = e_lce_cmd_uc_data;
          w_cmd.addr     = r_req.addr;
          w_cmd.data     = {{(BLOCK_W-DWORD_W){1'b0}}, w_blk_data[DWORD_W-1:0]};
          if (lce_cmd_ready_i) w_state_nxt = ST_IDLE;
        end
      end
      ST_UC_ST_MEM: begin
        w_mem_v    = 1'b1;
        w_mem_we   = 1'b1;
        w_mem_uc   = 1'b1;
        w_mem_addr = r_req.addr;
        w_mem_data = {{(BLOCK_W-DWORD_W){1'b0}}, r_req.data};
        if (mem_cmd_ready_i) w_state_nxt = ST_UC_DONE_CMD;
      end
      ST_UC_DONE_CMD: begin
        w_cmd_v        = 1'b1;
        w_cmd          = w_cmd_base;
        w_cmd.msg_type = e_lce_cmd_uc_st_done;
        w_cmd.addr     = r_req.addr;
        if (lce_cmd_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_req     <= '0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_req_yumi) r_req <= w_req;
      if (w_wb_take) begin
        r_wb_addr <= w_resp.addr;
        r_wb_data <= w_resp.data;
      end
    end
  end

  bp_cce_lite_mem_if #(.mem_lat_max_p(mem_lat_max_p)) u_mem_if (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .i_cmd_v         (w_mem_v),
    .i_we            (w_mem_we),
    .i_uc            (w_mem_uc),
    .i_addr          (w_mem_addr),
    .i_data          (w_mem_data),
    .i_wait          (w_mem_wait),
    .o_resp_done     (w_mem_resp_done),
    .o_dat_vld       (w_dat_vld),
    .o_data          (w_blk_data),
    .o_timeout       (timeout_o),
    .mem_cmd_addr_o  (mem_cmd_addr_o),
    .mem_cmd_we_o    (mem_cmd_we_o),
    .mem_cmd_uc_o    (mem_cmd_uc_o),
    .mem_cmd_data_o  (mem_cmd_data_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_resp_data_i (mem_resp_data_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_yumi_o (mem_resp_yumi_o)
  );

  assign lce_req_yumi_o  = w_req_yumi;
  assign lce_resp_yumi_o = w_resp_yumi;
  assign lce_cmd_v_o     = w_cmd_v;
  assign lce_cmd_o       = w_cmd;
  assign busy_o          = (r_state != ST_IDLE);

`ifdef BP_CCE_LITE_PERF_EN
  logic [31:0] r_perf_miss;
  logic [31:0] r_perf_wb;
  logic [31:0] r_perf_uc;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_perf_miss <= '0;
      r_perf_wb   <= '0;
      r_perf_uc   <= '0;
    end else begin
      if (w_req_yumi) begin
        if ((w_req.msg_type == e_lce_req_type_rd) || (w_req.msg_type == e_lce_req_type_wr))
          r_perf_miss <= sat_inc(r_perf_miss);
        else
          r_perf_uc <= sat_inc(r_perf_uc);
      end
      if (w_wb_take) r_perf_wb <= sat_inc(r_perf_wb);
    end
  end

  assign perf_miss_o = r_perf_miss;
  assign perf_wb_o   = r_perf_wb;
  assign perf_uc_o   = r_perf_uc;
`endif

endmodule

// File: tb/tb_bp_cce_lite_responder.sv
// Directed bench for bp_cce_lite_responder: coherent misses, writeback paths, uncached ops, backpressure, watchdog, reset.
module tb_bp_cce_lite_responder;
  import bp_cce_lite_pkg::*;

  localparam int MEM_LAT = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_lce_req_s        req;
  logic               req_v, req_yumi;
  bp_lce_cmd_s        cmd;
  logic               cmd_v, cmd_rdy;
  bp_lce_resp_s       resp;
  logic               resp_v, resp_yumi;
  logic [PADDR_W-1:0] m_addr;
  logic               m_we, m_uc, m_v, m_rdy;
  logic [BLOCK_W-1:0] m_data;
  logic [BLOCK_W-1:0] mr_data;
  logic               mr_v, mr_yumi;
  logic               busy, tmo;
`ifdef BP_CCE_LITE_PERF_EN
  logic [31:0] perf_miss, perf_wb, perf_uc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bp_cce_lite_responder #(.cce_id_p(0), .mem_lat_max_p(MEM_LAT)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .lce_req_i(req), .lce_req_v_i(req_v), .lce_req_yumi_o(req_yumi),
    .lce_cmd_o(cmd), .lce_cmd_v_o(cmd_v), .lce_cmd_ready_i(cmd_rdy),
    .lce_resp_i(resp), .lce_resp_v_i(resp_v), .lce_resp_yumi_o(resp_yumi),
    .mem_cmd_addr_o(m_addr), .mem_cmd_we_o(m_we), .mem_cmd_uc_o(m_uc),
    .mem_cmd_data_o(m_data), .mem_cmd_v_o(m_v), .mem_cmd_ready_i(m_rdy),
    .mem_resp_data_i(mr_data), .mem_resp_v_i(mr_v), .mem_resp_yumi_o(mr_yumi),
    .busy_o(busy), .timeout_o(tmo)
`ifdef BP_CCE_LITE_PERF_EN
    , .perf_miss_o(perf_miss), .perf_wb_o(perf_wb), .perf_uc_o(perf_uc)
`endif
  );

  task automatic check(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] out_flags();
    return {req_yumi, cmd_v, resp_yumi, m_v, mr_yumi, busy, tmo, m_we, m_uc};
  endfunction

  task automatic send_req(input lce_req_type_e t, input logic [PADDR_W-1:0] a,
                          input logic [WAY_W-1:0] way, input logic dirty, input logic [DWORD_W-1:0] d);
    int n = 0;
    req = '0;
    req.msg_type = t; req.addr = a; req.lru_way = way; req.lru_dirty = dirty; req.data = d;
    req_v = 1'b1;
    #1;
    while (!req_yumi && n < 200) begin @(negedge clk); #1; n++; end
    check("req_yumi", req_yumi, 1'b1);
    @(negedge clk);
    req_v = 1'b0;
  endtask

  task automatic take_cmd(output bp_lce_cmd_s c);
    int n = 0;
    while (!cmd_v && n < 200) begin @(negedge clk); n++; end
    check("cmd_seen", cmd_v, 1'b1);
    c = cmd;
    cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
  endtask

  task automatic take_mem(output logic [PADDR_W-1:0] a, output logic we, output logic uc,
                          output logic [BLOCK_W-1:0] d);
    int n = 0;
    while (!m_v && n < 200) begin @(negedge clk); n++; end
    check("mem_cmd_seen", m_v, 1'b1);
    a = m_addr; we = m_we; uc = m_uc; d = m_data;
    check("mem_lce_excl", cmd_v, 1'b0);
    m_rdy = 1'b1;
    @(negedge clk);
    m_rdy = 1'b0;
  endtask

  task automatic give_mem(input logic [BLOCK_W-1:0] d);
    int n = 0;
    mr_data = d; mr_v = 1'b1;
    #1;
    while (!mr_yumi && n < 200) begin @(negedge clk); #1; n++; end
    check("mem_resp_yumi", mr_yumi, 1'b1);
    @(negedge clk);
    mr_v = 1'b0; mr_data = '0;
  endtask

  task automatic give_resp(input lce_resp_type_e t, input logic [PADDR_W-1:0] a, input logic [BLOCK_W-1:0] d);
    int n = 0;
    resp = '0;
    resp.msg_type = t; resp.addr = a; resp.data = d;
    resp_v = 1'b1;
    #1;
    while (!resp_yumi && n < 200) begin @(negedge clk); #1; n++; end
    check("lce_resp_yumi", resp_yumi, 1'b1);
    @(negedge clk);
    resp_v = 1'b0;
  endtask

  logic [BLOCK_W-1:0] pat_a, pat_b, pat_c, uc_blk, exp_uc;
  bp_lce_cmd_s        c, first;
  logic [PADDR_W-1:0] a;
  logic               we, uc, stable, yumi_seen;
  logic [BLOCK_W-1:0] d;
  int                 n;

  initial begin
    req = '0; req_v = 0; cmd_rdy = 0; resp = '0; resp_v = 0;
    m_rdy = 0; mr_data = '0; mr_v = 0;
    pat_a  = {16{32'hA5A5_1234}};
    pat_b  = {16{32'hB0B0_CAFE}};
    pat_c  = {16{32'hC3C3_0F0F}};
    uc_blk = {{7{64'hFFFF_0000_FFFF_0000}}, 64'h0000_0000_DEAD_BEEF};
    exp_uc = {448'b0, 64'h0000_0000_DEAD_BEEF};

    repeat (3) @(negedge clk);
    check("reset_flags", out_flags(), 9'b0);
    check("reset_cmd", cmd, '0);
    check("reset_mem_addr", m_addr, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean read miss
    send_req(e_lce_req_type_rd, 40'h80_0000_0040, 3'd5, 1'b0, '0);
    take_mem(a, we, uc, d);
    check("rd_addr", a, 40'h80_0000_0040);
    check("rd_we_uc", {we, uc}, 2'b00);
    give_mem(pat_a);
    take_cmd(c);
    check("fill_type", c.msg_type, e_lce_cmd_data);
    check("fill_state_E", c.state, e_coh_E);
    check("fill_way", c.way_id, 3'd5);
    check("fill_data", c.data, pat_a);
    repeat (3) @(negedge clk);
    check("ack_wait_busy", busy, 1'b1);
    give_resp(e_lce_cce_coh_ack, '0, '0);
    check("rd_idle", busy, 1'b0);

    // Dirty write miss with writeback data
    send_req(e_lce_req_type_wr, 40'h00_0000_5A28, 3'd3, 1'b1, '0);
    take_cmd(c);
    check("wb_type", c.msg_type, e_lce_cmd_writeback);
    check("wb_way", c.way_id, 3'd3);
    check("wb_set", c.set_id, 6'h28);
    give_resp(e_lce_cce_resp_wb, 40'h00_0000_1000, pat_b);
    take_mem(a, we, uc, d);
    check("wbmem_we_uc", {we, uc}, 2'b10);
    check("wbmem_addr", a, 40'h00_0000_1000);
    check("wbmem_data", d, pat_b);
    take_mem(a, we, uc, d);
    check("wr_rd_we", we, 1'b0);
    check("wr_rd_addr", a, 40'h00_0000_5A00);
    give_mem(pat_a);
    take_cmd(c);
    check("wr_fill_state_M", c.state, e_coh_M);
    check("wr_fill_data", c.data, pat_a);
    check("wr_fill_way", c.way_id, 3'd3);
    give_resp(e_lce_cce_coh_ack, '0, '0);
    check("wr_idle", busy, 1'b0);

    // Dirty write miss answered with null_wb
    send_req(e_lce_req_type_wr, 40'h00_0000_5A28, 3'd3, 1'b1, '0);
    take_cmd(c);
    check("nwb_type", c.msg_type, e_lce_cmd_writeback);
    give_resp(e_lce_cce_resp_null_wb, 40'h00_0000_1000, pat_b);
    take_mem(a, we, uc, d);
    check("nwb_first_mem_is_read", we, 1'b0);
    check("nwb_rd_addr", a, 40'h00_0000_5A00);
    give_mem(pat_b);
    take_cmd(c);
    check("nwb_fill_state_M", c.state, e_coh_M);
    check("nwb_fill_data", c.data, pat_b);
    give_resp(e_lce_cce_coh_ack, '0, '0);

    // Uncached store then load
    send_req(e_lce_req_type_uc_wr, 40'h00_0000_2008, 3'd0, 1'b0, 64'h0000_0000_DEAD_BEEF);
    take_mem(a, we, uc, d);
    check("ucst_we_uc", {we, uc}, 2'b11);
    check("ucst_addr", a, 40'h00_0000_2008);
    check("ucst_data", d, exp_uc);
    take_cmd(c);
    check("ucst_done_type", c.msg_type, e_lce_cmd_uc_st_done);
    check("ucst_done_addr", c.addr, 40'h00_0000_2008);
    check("ucst_idle", busy, 1'b0);
    send_req(e_lce_req_type_uc_rd, 40'h00_0000_2008, 3'd0, 1'b0, '0);
    take_mem(a, we, uc, d);
    check("ucld_we_uc", {we, uc}, 2'b01);
    check("ucld_addr", a, 40'h00_0000_2008);
    give_mem(uc_blk);
    take_cmd(c);
    check("ucld_type", c.msg_type, e_lce_cmd_uc_data);
    check("ucld_data", c.data, exp_uc);
    check("ucld_idle_no_ack", busy, 1'b0);

    // Command backpressure with a second request pending
    send_req(e_lce_req_type_rd, 40'h00_0000_4080, 3'd1, 1'b0, '0);
    take_mem(a, we, uc, d);
    give_mem(pat_c);
    req = '0;
    req.msg_type = e_lce_req_type_uc_wr; req.addr = 40'h00_0000_3000; req.data = 64'h55;
    req_v = 1'b1;
    #1;
    first = cmd;
    stable = cmd_v;
    yumi_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (!cmd_v || cmd !== first) stable = 1'b0;
      if (req_yumi) yumi_seen = 1'b1;
    end
    check("bp_payload_stable", stable, 1'b1);
    check("bp_no_second_yumi", yumi_seen, 1'b0);
    check("bp_fill_data", first.data, pat_c);
    take_cmd(c);
    give_resp(e_lce_cce_coh_ack, '0, '0);
    #1;
    check("bp_second_yumi_at_idle", req_yumi, 1'b1);
    @(negedge clk);
    req_v = 1'b0;
    take_mem(a, we, uc, d);
    check("bp_second_addr", a, 40'h00_0000_3000);
    take_cmd(c);
    check("bp_second_done", c.msg_type, e_lce_cmd_uc_st_done);

    // Silent memory: watchdog, then reset mid-RD_RESP
    send_req(e_lce_req_type_rd, 40'h00_0000_6000, 3'd0, 1'b0, '0);
    take_mem(a, we, uc, d);
    repeat (500) @(negedge clk);
    check("wd_not_yet", tmo, 1'b0);
    n = 0;
    while (!tmo && n < 700) begin @(negedge clk); n++; end
    check("wd_timeout", tmo, 1'b1);
    check("wd_still_waiting", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_flags", out_flags(), 9'b0);
    check("midrst_cmd", cmd, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_req(e_lce_req_type_rd, 40'h80_0000_0040, 3'd2, 1'b0, '0);
    take_mem(a, we, uc, d);
    check("post_rst_rd_addr", a, 40'h80_0000_0040);
    give_mem(pat_a);
    take_cmd(c);
    check("post_rst_fill", {c.state, c.way_id}, {e_coh_E, 3'd2});
    check("post_rst_data", c.data, pat_a);
    give_resp(e_lce_cce_coh_ack, '0, '0);
    check("post_rst_idle_tmo", {busy, tmo}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
